// File: rtl/pipeline_hazard_control_if.sv
// Shared writeback-type encoding and the pipeline-side bundle seen by the hazard interlock.
// master = pipeline/datapath side, slave = hazard controller.
package pipeline_hazard_control_pkg;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_CSR = 2'd3
  } writebackType_;
endpackage

interface pipeline_hazard_control_if;
  import pipeline_hazard_control_pkg::*;

  logic          decodeExecuteValid;
  logic [4:0]    decodeExecuteRegister1;
  logic [4:0]    decodeExecuteRegister2;
  logic          decodeExecuteUsesRegister1;
  logic          decodeExecuteUsesRegister2;
  logic          executeMemoryValid;
  writebackType_ executeMemoryWritebackType;
  logic [4:0]    executeMemoryDestinationRegister;
  logic          executeMemoryMemRequest;
  logic          memoryReady;
  logic          redirect;
  logic          stallFetch;
  logic          stallDecode;
  logic          stallExecute;
  logic          bubbleExecuteMemory;
  logic          flushFetchDecode;
  logic          flushDecodeExecute;

  modport master (
    output decodeExecuteValid, decodeExecuteRegister1, decodeExecuteRegister2,
           decodeExecuteUsesRegister1, decodeExecuteUsesRegister2,
           executeMemoryValid, executeMemoryWritebackType,
           executeMemoryDestinationRegister, executeMemoryMemRequest,
           memoryReady, redirect,
    input  stallFetch, stallDecode, stallExecute, bubbleExecuteMemory,
           flushFetchDecode, flushDecodeExecute
  );

  modport slave (
    input  decodeExecuteValid, decodeExecuteRegister1, decodeExecuteRegister2,
           decodeExecuteUsesRegister1, decodeExecuteUsesRegister2,
           executeMemoryValid, executeMemoryWritebackType,
           executeMemoryDestinationRegister, executeMemoryMemRequest,
           memoryReady, redirect,
    output stallFetch, stallDecode, stallExecute, bubbleExecuteMemory,
           flushFetchDecode, flushDecodeExecute
  );
endinterface

// File: rtl/pipeline_hazard_control.sv
// Pipeline interlock: load-use bubbles, data-memory wait freezes and post-redirect
// fetch flush windows, plus a saturating stall-cycle counter.
module pipeline_hazard_control
  import pipeline_hazard_control_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_control_if.slave hz,
  output logic [1:0]             hazardState,
  output logic [COUNT_WIDTH-1:0] stallCycleCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [2:0]             flush_cnt_q, flush_cnt_d;
  logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic load_use_s;
  logic mem_wait_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic stall_fetch_s, stall_decode_s, stall_execute_s;
  logic bubble_s, flush_fd_s, flush_de_s;

  // Hazard detection terms.
  always_comb begin
    rs1_hit_s  = hz.decodeExecuteUsesRegister1 &
                 (hz.decodeExecuteRegister1 == hz.executeMemoryDestinationRegister);
    rs2_hit_s  = hz.decodeExecuteUsesRegister2 &
                 (hz.decodeExecuteRegister2 == hz.executeMemoryDestinationRegister);
    load_use_s = hz.decodeExecuteValid & hz.executeMemoryValid &
                 (hz.executeMemoryWritebackType == WB_MEM) &
                 (hz.executeMemoryDestinationRegister != 5'd0) &
                 (rs1_hit_s | rs2_hit_s);
    mem_wait_s = hz.executeMemoryValid & hz.executeMemoryMemRequest & ~hz.memoryReady;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    stall_fetch_s   = 1'b0;
    stall_decode_s  = 1'b0;
    stall_execute_s = 1'b0;
    bubble_s        = 1'b0;
    flush_fd_s      = 1'b0;
    flush_de_s      = 1'b0;
    if (!reset) begin
      state_d     = RUN;
      flush_cnt_d = 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.redirect) begin
            flush_fd_s = 1'b1;
            flush_de_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = REDIRECT;
              flush_cnt_d = FLUSH_RELOAD;
            end else begin
              state_d     = RUN;
            end
          end else if (mem_wait_s) begin
            stall_fetch_s   = 1'b1;
            stall_decode_s  = 1'b1;
            stall_execute_s = 1'b1;
            state_d         = MEM_WAIT;
          end else if (load_use_s) begin
            stall_fetch_s  = 1'b1;
            stall_decode_s = 1'b1;
            bubble_s       = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        MEM_WAIT: begin
          // Execute is frozen here, so a pending redirect is simply held off until RUN.
          stall_fetch_s   = 1'b1;
          stall_decode_s  = 1'b1;
          stall_execute_s = 1'b1;
          if (hz.memoryReady) begin
            state_d = RUN;
          end else begin
            state_d = MEM_WAIT;
          end
        end
        REDIRECT: begin
          flush_fd_s = 1'b1;
          if (mem_wait_s) begin
            stall_execute_s = 1'b1;
            stall_fetch_s   = 1'b1;
          end else if (hz.redirect) begin
            flush_de_s  = 1'b1;
            flush_cnt_d = FLUSH_RELOAD;
          end else if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d     = RUN;
          flush_cnt_d = 3'd0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    if (stall_fetch_s && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + COUNT_WIDTH'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State, flush window and performance counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= RUN;
      flush_cnt_q   <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.stallFetch          = stall_fetch_s;
  assign hz.stallDecode         = stall_decode_s;
  assign hz.stallExecute        = stall_execute_s;
  assign hz.bubbleExecuteMemory = bubble_s;
  assign hz.flushFetchDecode    = flush_fd_s;
  assign hz.flushDecodeExecute  = flush_de_s;
  assign hazardState            = state_q;
  assign stallCycleCount        = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Directed bench: dut_a (FLUSH_CYCLES=2, 32-bit count) and dut_b (FLUSH_CYCLES=3,
// 4-bit count) see identical stimulus; controls are packed {SF,SD,SE,BU,FF,FD}.
module tb_pipeline_hazard_control;
  import pipeline_hazard_control_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  hz_a, hz_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [5:0]  ctl_a, ctl_b;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  pipeline_hazard_control_if if_a ();
  pipeline_hazard_control_if if_b ();

  assign if_b.decodeExecuteValid               = if_a.decodeExecuteValid;
  assign if_b.decodeExecuteRegister1           = if_a.decodeExecuteRegister1;
  assign if_b.decodeExecuteRegister2           = if_a.decodeExecuteRegister2;
  assign if_b.decodeExecuteUsesRegister1       = if_a.decodeExecuteUsesRegister1;
  assign if_b.decodeExecuteUsesRegister2       = if_a.decodeExecuteUsesRegister2;
  assign if_b.executeMemoryValid               = if_a.executeMemoryValid;
  assign if_b.executeMemoryWritebackType       = if_a.executeMemoryWritebackType;
  assign if_b.executeMemoryDestinationRegister = if_a.executeMemoryDestinationRegister;
  assign if_b.executeMemoryMemRequest          = if_a.executeMemoryMemRequest;
  assign if_b.memoryReady                      = if_a.memoryReady;
  assign if_b.redirect                         = if_a.redirect;

  assign ctl_a = {if_a.stallFetch, if_a.stallDecode, if_a.stallExecute,
                  if_a.bubbleExecuteMemory, if_a.flushFetchDecode, if_a.flushDecodeExecute};
  assign ctl_b = {if_b.stallFetch, if_b.stallDecode, if_b.stallExecute,
                  if_b.bubbleExecuteMemory, if_b.flushFetchDecode, if_b.flushDecodeExecute};

  pipeline_hazard_control #(.FLUSH_CYCLES(2), .COUNT_WIDTH(32)) dut_a (
    .clock(clock), .reset(reset), .hz(if_a), .hazardState(hz_a), .stallCycleCount(cnt_a)
  );
  pipeline_hazard_control #(.FLUSH_CYCLES(3), .COUNT_WIDTH(4)) dut_b (
    .clock(clock), .reset(reset), .hz(if_b), .hazardState(hz_b), .stallCycleCount(cnt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    if_a.decodeExecuteValid               = 1'b0;
    if_a.decodeExecuteRegister1           = 5'd0;
    if_a.decodeExecuteRegister2           = 5'd0;
    if_a.decodeExecuteUsesRegister1       = 1'b0;
    if_a.decodeExecuteUsesRegister2       = 1'b0;
    if_a.executeMemoryValid               = 1'b0;
    if_a.executeMemoryWritebackType       = WB_ALU;
    if_a.executeMemoryDestinationRegister = 5'd0;
    if_a.executeMemoryMemRequest          = 1'b0;
    if_a.memoryReady                      = 1'b0;
    if_a.redirect                         = 1'b0;
  endtask

  // lw x5 in EX/MEM, add x6,x1,x5 in DE/EX
  task automatic drive_load_use();
    if_a.decodeExecuteValid               = 1'b1;
    if_a.decodeExecuteRegister1           = 5'd1;
    if_a.decodeExecuteRegister2           = 5'd5;
    if_a.decodeExecuteUsesRegister1       = 1'b1;
    if_a.decodeExecuteUsesRegister2       = 1'b1;
    if_a.executeMemoryValid               = 1'b1;
    if_a.executeMemoryWritebackType       = WB_MEM;
    if_a.executeMemoryDestinationRegister = 5'd5;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    tick();
    tick();
    drive_load_use();
    #1;
    total++; if (ctl_a !== 6'b000000) begin bad++; $display("FAIL rst_ctl got=%b want=%b", ctl_a, 6'b000000); end
    total++; if (hz_a !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=%0d", hz_a, 0); end
    total++; if (cnt_a !== 32'd0) begin bad++; $display("FAIL rst_cnt_a got=%0d want=%0d", cnt_a, 0); end
    total++; if (cnt_b !== 4'd0) begin bad++; $display("FAIL rst_cnt_b got=%0d want=%0d", cnt_b, 0); end
    drive_idle();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    drive_load_use();
    #1;
    total++; if (ctl_a !== 6'b110100) begin bad++; $display("FAIL lu_rs2 got=%b want=%b", ctl_a, 6'b110100); end
    tick();
    exp_cnt = exp_cnt + 1;
    if_a.executeMemoryValid = 1'b0;
    #1;
    total++; if (ctl_a !== 6'b000000) begin bad++; $display("FAIL lu_after got=%b want=%b", ctl_a, 6'b000000); end
    total++; if (cnt_a !== 32'(exp_cnt)) begin bad++; $display("FAIL lu_cnt got=%0d want=%0d", cnt_a, exp_cnt); end
    if_a.executeMemoryValid               = 1'b1;
    if_a.executeMemoryDestinationRegister = 5'd0;
    if_a.decodeExecuteRegister2           = 5'd0;
    #1;
    total++; if (ctl_a !== 6'b000000) begin bad++; $display("FAIL lu_rd0 got=%b want=%b", ctl_a, 6'b000000); end
    if_a.executeMemoryDestinationRegister = 5'd5;
    if_a.decodeExecuteRegister2           = 5'd5;
    if_a.decodeExecuteUsesRegister2       = 1'b0;
    #1;
    total++; if (ctl_a !== 6'b000000) begin bad++; $display("FAIL lu_nouse2 got=%b want=%b", ctl_a, 6'b000000); end
    if_a.decodeExecuteRegister1 = 5'd5;
    #1;
    total++; if (ctl_a !== 6'b110100) begin bad++; $display("FAIL lu_rs1 got=%b want=%b", ctl_a, 6'b110100); end
    tick();
    exp_cnt = exp_cnt + 1;
    drive_idle();
    tick();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 5; i++) begin
      if_a.executeMemoryValid      = 1'b1;
      if_a.executeMemoryMemRequest = (i < 4);
      if_a.memoryReady             = (i == 3);
      #1;
      total++; if (hz_a !== ((i == 0 || i == 4) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL mw_state[%0d] got=%0d", i, hz_a); end
      total++; if (ctl_a !== ((i < 4) ? 6'b111000 : 6'b000000)) begin bad++; $display("FAIL mw_ctl[%0d] got=%b", i, ctl_a); end
      tick();
    end
    exp_cnt = exp_cnt + 4;
    total++; if (cnt_a !== 32'(exp_cnt)) begin bad++; $display("FAIL mw_cnt got=%0d want=%0d", cnt_a, exp_cnt); end
    drive_idle();
  endtask

  task automatic test_redirect();
    if_a.redirect = 1'b1;
    #1;
    total++; if (ctl_a !== 6'b000011) begin bad++; $display("FAIL rd_c0 got=%b want=%b", ctl_a, 6'b000011); end
    tick();
    if_a.redirect = 1'b0;
    #1;
    total++; if (ctl_a !== 6'b000010) begin bad++; $display("FAIL rd_c1 got=%b want=%b", ctl_a, 6'b000010); end
    total++; if (hz_a !== 2'd2) begin bad++; $display("FAIL rd_c1_state got=%0d want=%0d", hz_a, 2); end
    tick();
    total++; if (ctl_a !== 6'b000000) begin bad++; $display("FAIL rd_c2 got=%b want=%b", ctl_a, 6'b000000); end
    total++; if (hz_a !== 2'd0) begin bad++; $display("FAIL rd_c2_state got=%0d want=%0d", hz_a, 0); end
    tick();
    // memory wait arriving inside the flush window freezes the window
    if_a.redirect = 1'b1;
    tick();
    if_a.redirect                = 1'b0;
    if_a.executeMemoryValid      = 1'b1;
    if_a.executeMemoryMemRequest = 1'b1;
    #1;
    total++; if (ctl_a !== 6'b101010) begin bad++; $display("FAIL rd_mw got=%b want=%b", ctl_a, 6'b101010); end
    tick();
    exp_cnt = exp_cnt + 1;
    drive_idle();
    #1;
    total++; if (hz_a !== 2'd2 || ctl_a !== 6'b000010) begin bad++; $display("FAIL rd_hold got=%0d/%b want=2/000010", hz_a, ctl_a); end
    tick();
    total++; if (hz_a !== 2'd0) begin bad++; $display("FAIL rd_hold_exit got=%0d want=%0d", hz_a, 0); end
    tick();
  endtask

  task automatic test_simultaneous();
    drive_load_use();
    if_a.executeMemoryMemRequest = 1'b1;
    if_a.redirect                = 1'b1;
    #1;
    total++; if (ctl_a !== 6'b000011) begin bad++; $display("FAIL sim_all got=%b want=%b", ctl_a, 6'b000011); end
    tick();
    drive_idle();
    tick();
    tick();
    if_a.executeMemoryValid      = 1'b1;
    if_a.executeMemoryMemRequest = 1'b1;
    tick();
    if_a.redirect = 1'b1;
    #1;
    total++; if (ctl_a !== 6'b111000 || hz_a !== 2'd1) begin bad++; $display("FAIL held_mw got=%b/%0d want=111000/1", ctl_a, hz_a); end
    tick();
    if_a.memoryReady = 1'b1;
    #1;
    total++; if (ctl_a !== 6'b111000) begin bad++; $display("FAIL held_ready got=%b want=%b", ctl_a, 6'b111000); end
    tick();
    if_a.executeMemoryMemRequest = 1'b0;
    #1;
    total++; if (ctl_a !== 6'b000011 || hz_a !== 2'd0) begin bad++; $display("FAIL held_flush got=%b/%0d want=000011/0", ctl_a, hz_a); end
    tick();
    exp_cnt = exp_cnt + 3;
    drive_idle();
    tick();
    tick();
    total++; if (cnt_a !== 32'(exp_cnt)) begin bad++; $display("FAIL sim_cnt got=%0d want=%0d", cnt_a, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    if_a.redirect = 1'b1;
    #1;
    total++; if (ctl_b !== 6'b000011) begin bad++; $display("FAIL b2b_c0 got=%b want=%b", ctl_b, 6'b000011); end
    tick();
    if_a.redirect = 1'b0;
    #1;
    total++; if (ctl_b !== 6'b000010 || hz_b !== 2'd2) begin bad++; $display("FAIL b2b_c1 got=%b/%0d want=000010/2", ctl_b, hz_b); end
    tick();
    if_a.redirect = 1'b1;
    #1;
    total++; if (ctl_b !== 6'b000011 || hz_b !== 2'd2) begin bad++; $display("FAIL b2b_again got=%b/%0d want=000011/2", ctl_b, hz_b); end
    tick();
    if_a.redirect = 1'b0;
    #1;
    total++; if (ctl_b !== 6'b000010 || hz_b !== 2'd2) begin bad++; $display("FAIL b2b_c3 got=%b/%0d want=000010/2", ctl_b, hz_b); end
    tick();
    total++; if (ctl_b !== 6'b000010 || hz_b !== 2'd2) begin bad++; $display("FAIL b2b_reload got=%b/%0d want=000010/2", ctl_b, hz_b); end
    tick();
    total++; if (ctl_b !== 6'b000000 || hz_b !== 2'd0) begin bad++; $display("FAIL b2b_end got=%b/%0d want=000000/0", ctl_b, hz_b); end
    tick();
  endtask

  task automatic test_reset_mid();
    if_a.executeMemoryValid      = 1'b1;
    if_a.executeMemoryMemRequest = 1'b1;
    tick();
    total++; if (hz_a !== 2'd1) begin bad++; $display("FAIL rm_in_mw got=%0d want=%0d", hz_a, 1); end
    reset = 1'b0;
    #1;
    total++; if (ctl_a !== 6'b000000) begin bad++; $display("FAIL rm_out got=%b want=%b", ctl_a, 6'b000000); end
    tick();
    total++; if (hz_a !== 2'd0 || cnt_a !== 32'd0 || cnt_b !== 4'd0) begin bad++; $display("FAIL rm_state got=%0d/%0d/%0d want=0/0/0", hz_a, cnt_a, cnt_b); end
    exp_cnt = 0;
    reset = 1'b1;
    drive_idle();
    if_a.redirect = 1'b1;
    tick();
    if_a.redirect = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (ctl_a !== 6'b000000) begin bad++; $display("FAIL rr_out got=%b want=%b", ctl_a, 6'b000000); end
    tick();
    reset = 1'b1;
    #1;
    total++; if (hz_a !== 2'd0 || hz_b !== 2'd0) begin bad++; $display("FAIL rr_state got=%0d/%0d want=0/0", hz_a, hz_b); end
    tick();
  endtask

  task automatic test_saturation();
    if_a.executeMemoryValid      = 1'b1;
    if_a.executeMemoryMemRequest = 1'b1;
    repeat (20) tick();
    exp_cnt = exp_cnt + 20;
    total++; if (cnt_a !== 32'(exp_cnt)) begin bad++; $display("FAIL sat_cnt_a got=%0d want=%0d", cnt_a, exp_cnt); end
    total++; if (cnt_b !== 4'd15) begin bad++; $display("FAIL sat_cnt_b got=%0d want=%0d", cnt_b, 15); end
    if_a.memoryReady = 1'b1;
    tick();
    exp_cnt = exp_cnt + 1;
    drive_idle();
    tick();
    total++; if (cnt_b !== 4'd15 || cnt_a !== 32'(exp_cnt)) begin bad++; $display("FAIL sat_hold got=%0d/%0d want=15/%0d", cnt_b, cnt_a, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
